branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//   Carries each fetched instruction's BTB prediction alongside it through the IF/ID and ID/EX
//   stages, and compares the prediction with the branch outcome resolved in EX.
//   On a wrong prediction it raises a flush and supplies the redirect PC to the fetch stage.
//   One cycle later it drives the BTB write port (PCWrite / PCWritePredict / StateBitWritePredict),
//   so the BTB learns from every mispredict.
// PARAMETERS
//   PC_W   32  PC/target width; only 32 is supported.
//   CNT_W  32  width of the performance counters (used only with BRU_PERF_CNT_EN).
// PORTS
//   clk              in   1      clock, rising edge
//   rst              in   1      reset, asynchronous, active-high
//   if_valid         in   1      the IF stage holds a real instruction this cycle
//   if_pc            in   PC_W   PC of the instruction in IF (also drives BTB PCRead)
//   if_pred_taken    in   1      BTB ReadPredict for if_pc
//   if_pred_target   in   PC_W   BTB PCReadPredict for if_pc
//   stall_id         in   1      load-use stall: hold the ID tag, insert a bubble into EX
//   flush_id         in   1      external ID flush (jal in ID): clear the ID tag at the edge
//   ex_is_branch     in   1      the instruction in EX is a conditional branch
//   ex_taken         in   1      actual branch outcome (valid when ex_is_branch)
//   ex_target        in   PC_W   actual branch target (valid when ex_is_branch)
//   mispredict       out  1      combinational: flush IF/ID and ID/EX this cycle
//   redirect_pc      out  PC_W   combinational: next fetch PC when mispredict=1, else 0
//   btb_write        out  1      registered BTBWrite strobe, one cycle wide
//   btb_pc_write     out  PC_W   registered PCWrite
//   btb_pc_predict   out  PC_W   registered PCWritePredict
//   btb_state_bit    out  1      registered StateBitWritePredict
//   cnt_branch       out  CNT_W  resolved conditional branches
//   cnt_mispredict   out  CNT_W  mispredicts
// BEHAVIOUR
//   - Tag registers: ID={v,pc,pt,tgt} and EX={v,pc,pt,tgt}. On reset every field is 0.
//   - Reset values of all outputs are 0; the counters reset to 0.
//   - Tag update at each rising edge, in priority order:
//       * mispredict=1 -> ID.v=0, EX.v=0 (overrides stall_id and flush_id);
//       * otherwise stall_id=1 -> ID holds, EX.v=0;
//       * otherwise EX<=ID, then ID<=IF fields with v=if_valid&~flush_id.
//   - Mispredict is evaluated when EX.v=1 (all arithmetic is mod 2^32):
//       * branch, taken, pt=0                -> mispredict, redirect=ex_target
//       * branch, taken, pt=1, tgt!=ex_target -> mispredict, redirect=ex_target
//       * branch, not taken, pt=1             -> mispredict, redirect=EX.pc+4
//       * non-branch, pt=1 (stale/aliased)    -> mispredict, redirect=EX.pc+4
//       * all other cases                      -> mispredict=0, redirect_pc=0
//   - BTB write, registered at the edge that ends a mispredict cycle:
//       * btb_write=1 for exactly one cycle;
//       * btb_pc_write=EX.pc;
//       * btb_pc_predict = ex_target for a branch, 0 for a non-branch;
//       * btb_state_bit = ex_is_branch & ex_taken, so a non-branch writes state 0 (invalidate).
//   - Otherwise btb_write=0, and the btb data outputs hold their last value.
//   - Latency: the BTB entry is updated 2 edges after resolution (this unit's edge + the BTB's edge).
//   - Back-to-back mispredicts are impossible: a mispredict clears EX for the next cycle.
//   - rst asserted mid-operation clears everything immediately; mispredict drops asynchronously.
// CONFIGURATION
//   - BRU_PERF_CNT_EN defined:
//       * cnt_branch increments when EX.v & ex_is_branch;
//       * cnt_mispredict increments when mispredict=1;
//       * both saturate at all-ones.
//   - BRU_PERF_CNT_EN undefined: cnt_branch and cnt_mispredict are tied to 0 and no counter
//     flops are built.
// TESTING
//   1. Cold miss: if_pc=0x100, pt=0, a branch taken to 0x140 reaches EX ->
//      mispredict=1, redirect=0x140; next cycle btb_write=1, pc=0x100, predict=0x140, state=1.
//   2. Correct taken: pt=1, tgt=0x140, ex_taken=1, ex_target=0x140 ->
//      mispredict=0, no btb_write, cnt_branch+1.
//   3. Predicted taken but falls through at pc=0x200 -> redirect=0x204;
//      next cycle btb_write with state=0.
//   4. Target change: pt=1, tgt=0x300, actual taken to 0x380 ->
//      redirect=0x380, write predict=0x380.
//   5. stall_id=1 for 1 cycle with a branch in ID -> EX gets a bubble; the branch resolves
//      1 cycle later with its original prediction.
//   6. Mispredict together with stall_id=1 and flush_id=1 -> both tags cleared.
//      Additionally, rst pulsed mid-mispredict -> all outputs 0 immediately.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: carries BTB predictions through ID/EX, flags mispredicts, and writes the BTB back.
// Optional performance counters are built when BRU_PERF_CNT_EN is defined.
module branch_resolve_unit #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [PC_W-1:0]  if_pc,
  input  logic             if_pred_taken,
  input  logic [PC_W-1:0]  if_pred_target,
  input  logic             stall_id,
  input  logic             flush_id,
  input  logic             ex_is_branch,
  input  logic             ex_taken,
  input  logic [PC_W-1:0]  ex_target,
  output logic             mispredict,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             btb_write,
  output logic [PC_W-1:0]  btb_pc_write,
  output logic [PC_W-1:0]  btb_pc_predict,
  output logic             btb_state_bit,
  output logic [CNT_W-1:0] cnt_branch,
  output logic [CNT_W-1:0] cnt_mispredict
);

  logic            id_v, id_pt, ex_v, ex_pt;
  logic [PC_W-1:0] id_pc, id_tgt, ex_pc, ex_tgt;

  always_comb begin
    mispredict  = 1'b0;
    redirect_pc = '0;
    if (ex_v) begin
      if (ex_is_branch) begin
        if (ex_taken && (!ex_pt || ex_tgt != ex_target)) begin
          mispredict  = 1'b1;
          redirect_pc = ex_target;
        end else if (!ex_taken && ex_pt) begin
          mispredict  = 1'b1;
          redirect_pc = ex_pc + PC_W'(4);
        end
      end else if (ex_pt) begin
        // Stale or aliased BTB hit on a non-branch: fall through and invalidate
        mispredict  = 1'b1;
        redirect_pc = ex_pc + PC_W'(4);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_v   <= 1'b0;
      id_pt  <= 1'b0;
      id_pc  <= '0;
      id_tgt <= '0;
      ex_v   <= 1'b0;
      ex_pt  <= 1'b0;
      ex_pc  <= '0;
      ex_tgt <= '0;
    end else if (mispredict) begin
      id_v <= 1'b0;
      ex_v <= 1'b0;
    end else if (stall_id) begin
      ex_v <= 1'b0;
    end else begin
      ex_v   <= id_v;
      ex_pt  <= id_pt;
      ex_pc  <= id_pc;
      ex_tgt <= id_tgt;
      id_v   <= if_valid & ~flush_id;
      id_pt  <= if_pred_taken;
      id_pc  <= if_pc;
      id_tgt <= if_pred_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btb_write      <= 1'b0;
      btb_pc_write   <= '0;
      btb_pc_predict <= '0;
      btb_state_bit  <= 1'b0;
    end else if (mispredict) begin
      btb_write      <= 1'b1;
      btb_pc_write   <= ex_pc;
      btb_pc_predict <= ex_is_branch ? ex_target : '0;
      btb_state_bit  <= ex_is_branch & ex_taken;
    end else begin
      btb_write <= 1'b0;
    end
  end

`ifdef BRU_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_branch     <= '0;
      cnt_mispredict <= '0;
    end else begin
      if (ex_v && ex_is_branch && cnt_branch != '1)
        cnt_branch <= cnt_branch + CNT_W'(1);
      if (mispredict && cnt_mispredict != '1)
        cnt_mispredict <= cnt_mispredict + CNT_W'(1);
    end
  end
`else
  assign cnt_branch     = '0;
  assign cnt_mispredict = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: per-instruction pipeline model plus literal scenario checks.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_valid, if_pred_taken, stall_id, flush_id;
  logic        ex_is_branch, ex_taken;
  logic [31:0] if_pc, if_pred_target, ex_target;
  logic        mispredict, btb_write, btb_state_bit;
  logic [31:0] redirect_pc, btb_pc_write, btb_pc_predict, cnt_branch, cnt_mispredict;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.PC_W(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc),
    .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target),
    .stall_id(stall_id), .flush_id(flush_id), .ex_is_branch(ex_is_branch),
    .ex_taken(ex_taken), .ex_target(ex_target), .mispredict(mispredict),
    .redirect_pc(redirect_pc), .btb_write(btb_write), .btb_pc_write(btb_pc_write),
    .btb_pc_predict(btb_pc_predict), .btb_state_bit(btb_state_bit),
    .cnt_branch(cnt_branch), .cnt_mispredict(cnt_mispredict)
  );

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] tgt;
  } tag_t;

  typedef struct packed {
    logic        mp;
    logic [31:0] rd;
  } res_t;

  // Outcome of an instruction's prediction given what EX learned about it
  function automatic res_t resolve(tag_t t, logic br, logic tk, logic [31:0] tgt);
    res_t r;
    logic [31:0] fall;
    logic [31:0] correct;
    fall    = t.pc + 32'd4;
    correct = (br && tk) ? tgt : fall;
    r.mp = 1'b0;
    r.rd = 32'd0;
    if (t.v) begin
      if ((t.pt ? t.tgt : fall) != correct || (t.pt && !(br && tk))) begin
        r.mp = 1'b1;
        r.rd = correct;
      end
    end
    return r;
  endfunction

  tag_t        m_id, m_ex;
  logic        m_bw, m_bst;
  logic [31:0] m_bpc, m_bpred, m_cb, m_cm;
  res_t        r_now;

  assign r_now = resolve(m_ex, ex_is_branch, ex_taken, ex_target);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_id <= '0; m_ex <= '0;
      m_bw <= 1'b0; m_bst <= 1'b0; m_bpc <= '0; m_bpred <= '0;
      m_cb <= '0; m_cm <= '0;
    end else begin
      m_bw <= r_now.mp;
      if (r_now.mp) begin
        m_bpc   <= m_ex.pc;
        m_bpred <= ex_is_branch ? ex_target : 32'd0;
        m_bst   <= ex_is_branch & ex_taken;
        m_id.v  <= 1'b0;
        m_ex.v  <= 1'b0;
      end else if (stall_id) begin
        m_ex.v <= 1'b0;
      end else begin
        m_ex <= m_id;
        m_id <= '{v: if_valid && !flush_id, pc: if_pc, pt: if_pred_taken, tgt: if_pred_target};
      end
      if (m_ex.v && ex_is_branch && m_cb != 32'hFFFF_FFFF) m_cb <= m_cb + 32'd1;
      if (r_now.mp && m_cm != 32'hFFFF_FFFF) m_cm <= m_cm + 32'd1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("model_mispredict", {31'd0, mispredict}, {31'd0, r_now.mp});
      chk("model_redirect", redirect_pc, r_now.rd);
      chk("model_btb_write", {31'd0, btb_write}, {31'd0, m_bw});
      chk("model_btb_pc", btb_pc_write, m_bpc);
      chk("model_btb_predict", btb_pc_predict, m_bpred);
      chk("model_btb_state", {31'd0, btb_state_bit}, {31'd0, m_bst});
`ifdef BRU_PERF_CNT_EN
      chk("model_cnt_branch", cnt_branch, m_cb);
      chk("model_cnt_mispredict", cnt_mispredict, m_cm);
`else
      chk("cnt_branch_tied", cnt_branch, 32'd0);
      chk("cnt_mispredict_tied", cnt_mispredict, 32'd0);
`endif
    end
  end

  task automatic idle();
    if_valid = 0; if_pc = '0; if_pred_taken = 0; if_pred_target = '0;
    stall_id = 0; flush_id = 0; ex_is_branch = 0; ex_taken = 0; ex_target = '0;
  endtask

  // Advance to just after the next rising edge with all inputs idle
  task automatic go();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic fetch(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
    if_valid = 1; if_pc = pc; if_pred_taken = pt; if_pred_target = tgt;
  endtask

  task automatic resolve_ex(input logic br, input logic tk, input logic [31:0] tgt);
    ex_is_branch = br; ex_taken = tk; ex_target = tgt;
  endtask

  task automatic expect_mp(input string name, input logic mp, input logic [31:0] rd);
    #2;
    chk({name, "_mp"}, {31'd0, mispredict}, {31'd0, mp});
    chk({name, "_redirect"}, redirect_pc, rd);
  endtask

  task automatic expect_btb(input string name, input logic [31:0] pc, input logic [31:0] pred, input logic st);
    #2;
    chk({name, "_bw"}, {31'd0, btb_write}, 32'd1);
    chk({name, "_bpc"}, btb_pc_write, pc);
    chk({name, "_bpred"}, btb_pc_predict, pred);
    chk({name, "_bst"}, {31'd0, btb_state_bit}, {31'd0, st});
  endtask

  initial begin
    idle();
    #2;
    chk("reset_mp", {31'd0, mispredict}, 32'd0);
    chk("reset_redirect", redirect_pc, 32'd0);
    chk("reset_btb_write", {31'd0, btb_write}, 32'd0);
    chk("reset_btb_pc", btb_pc_write, 32'd0);
    chk("reset_cnt", cnt_branch | cnt_mispredict, 32'd0);
    #10 rst = 0;

    // 1: cold miss
    go(); fetch(32'h100, 0, 32'h0);
    go();
    go(); resolve_ex(1, 1, 32'h140); expect_mp("cold", 1, 32'h140);
    go(); expect_btb("cold", 32'h100, 32'h140, 1);
    chk("cold_mp_cleared", {31'd0, mispredict}, 32'd0);
    go(); #2 chk("cold_bw_one_cycle", {31'd0, btb_write}, 32'd0);
    chk("cold_bpc_hold", btb_pc_write, 32'h100);

    // 2: correct taken
    go(); fetch(32'h100, 1, 32'h140);
    go();
    go(); resolve_ex(1, 1, 32'h140); expect_mp("ok_taken", 0, 32'h0);
    go(); #2 chk("ok_taken_no_bw", {31'd0, btb_write}, 32'd0);

    // 3: predicted taken, falls through
    go(); fetch(32'h200, 1, 32'h240);
    go();
    go(); resolve_ex(1, 0, 32'h240); expect_mp("fallthru", 1, 32'h204);
    go(); expect_btb("fallthru", 32'h200, 32'h240, 0);

    // 4: target change
    go(); fetch(32'h300, 1, 32'h300);
    go();
    go(); resolve_ex(1, 1, 32'h380); expect_mp("retarget", 1, 32'h380);
    go(); expect_btb("retarget", 32'h300, 32'h380, 1);

    // 5: stall with branch in ID
    go(); fetch(32'h400, 1, 32'h440);
    go(); stall_id = 1; fetch(32'h500, 0, 32'h0);
    go(); resolve_ex(1, 1, 32'h480); expect_mp("stall_bubble", 0, 32'h0);
    go(); resolve_ex(1, 1, 32'h480); expect_mp("stall_late", 1, 32'h480);
    go(); expect_btb("stall_late", 32'h400, 32'h480, 1);

    // Non-branch with a stale taken prediction, wrapping past 2^32
    go(); fetch(32'hFFFF_FFFC, 1, 32'h40);
    go();
    go(); resolve_ex(0, 0, 32'h1234); expect_mp("stale", 1, 32'h0);
    go(); expect_btb("stale", 32'hFFFF_FFFC, 32'h0, 0);

    // 6: mispredict with stall_id and flush_id together
    go(); fetch(32'h700, 0, 32'h0);
    go(); fetch(32'h704, 0, 32'h0);
    go(); resolve_ex(1, 1, 32'h780); stall_id = 1; flush_id = 1; fetch(32'h708, 1, 32'h0);
    expect_mp("prio", 1, 32'h780);
    go(); resolve_ex(1, 1, 32'h999); expect_mp("prio_ex_clr", 0, 32'h0);
    go(); resolve_ex(1, 1, 32'h999); expect_mp("prio_id_clr", 0, 32'h0);

    // rst pulsed during a mispredict
    go(); fetch(32'h800, 0, 32'h0);
    go();
    go(); resolve_ex(1, 1, 32'h840); expect_mp("rst_pre", 1, 32'h840);
    rst = 1;
    #1;
    chk("rst_async_mp", {31'd0, mispredict}, 32'd0);
    chk("rst_async_redirect", redirect_pc, 32'd0);
    chk("rst_async_bpc", btb_pc_write, 32'd0);
    chk("rst_async_bpred", btb_pc_predict, 32'd0);
    @(posedge clk);
    #1 rst = 0;
    go(); #2 chk("rst_after_bw", {31'd0, btb_write}, 32'd0);
    go(); go();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
